// File: rtl/ib_mul_pkg.sv
// Shared definitions for the quarter-square multiply scheduler.
//   - mul_state_e : scheduler FSM encoding (2 bits)
//   - MUL_OP_W    : operand width
//   - MUL_SQ_W    : squarer input width (holds a+b up to 510)
//   - MUL_RES_W   : product / squarer output width
package ib_mul_pkg;

    localparam int MUL_OP_W  = 8;
    localparam int MUL_SQ_W  = 9;
    localparam int MUL_RES_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQ_SUM = 2'd1,
        SQ_DIF = 2'd2,
        RESP   = 2'd3
    } mul_state_e;

endpackage

// File: rtl/ib_mul_qs_sched_if.sv
// Request/response bundle between the requester fabric and ib_mul_qs_sched.
//   i_req_valid / o_req_ready : per-requester handshake (ready one-hot or zero)
//   i_req_a / i_req_b         : packed operands, requester k at [8k+7:8k]
//   o_rsp_valid / i_rsp_ready : product handshake
//   o_rsp_c / o_rsp_id        : product and issuing requester index
//   o_busy                    : scheduler not idle
// master = requester/consumer side, slave = scheduler side.
interface ib_mul_qs_sched_if #(
    parameter int N_REQ = 4
);
    import ib_mul_pkg::*;

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]          i_req_valid;
    logic [N_REQ-1:0]          o_req_ready;
    logic [MUL_OP_W*N_REQ-1:0] i_req_a;
    logic [MUL_OP_W*N_REQ-1:0] i_req_b;
    logic                      o_rsp_valid;
    logic                      i_rsp_ready;
    logic [MUL_RES_W-1:0]      o_rsp_c;
    logic [ID_W-1:0]           o_rsp_id;
    logic                      o_busy;

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_c, o_rsp_id, o_busy
    );

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_c, o_rsp_id, o_busy
    );

endinterface

// File: rtl/ib_mul_qs_sq9.sv
// Shared quarter-squarer: y = (x*x) >> 2.
//   x : 9-bit unsigned input
//   y : 16-bit result (max 510^2/4 = 65025 fits exactly)
module ib_mul_qs_sq9
    import ib_mul_pkg::*;
(
    input  logic [MUL_SQ_W-1:0]  x,
    output logic [MUL_RES_W-1:0] y
);

    logic [2*MUL_SQ_W-1:0] sq;

    assign sq = {{MUL_SQ_W{1'b0}}, x} * {{MUL_SQ_W{1'b0}}, x};
    assign y  = MUL_RES_W'(sq >> 2);

endmodule

// File: rtl/ib_mul_qs_sched.sv
// Round-robin scheduler sharing one quarter-square multiplier among N_REQ
// requesters. a*b = floor((a+b)^2/4) - floor((a-b)^2/4), computed with a
// single squarer over two cycles.
// Ports:
//   i_clk  : clock
//   i_nrst : synchronous active-low reset
//   bus    : ib_mul_qs_sched_if.slave (request/response handshakes, o_busy)
// Build option: IB_MUL_QS_SCHED_ZERO_SKIP_EN -- when defined, a zero operand
// jumps straight from IDLE to RESP with a zero product.
//
// state  | meaning
// IDLE   | waiting; round-robin grant offered on o_req_ready
// SQ_SUM | acc <= (a+b)^2/4
// SQ_DIF | acc <= acc - |a-b|^2/4
// RESP   | product presented until consumer accepts
module ib_mul_qs_sched
    import ib_mul_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    ib_mul_qs_sched_if.slave   bus
);

    localparam int ID_W = $clog2(N_REQ);

    mul_state_e           state, state_nxt;
    logic [ID_W-1:0]      rr_ptr, id_q, grant_id;
    logic                 grant_vld, accept;
    logic [MUL_OP_W-1:0]  ops_a [N_REQ];
    logic [MUL_OP_W-1:0]  ops_b [N_REQ];
    logic [MUL_OP_W-1:0]  a_q, b_q;
    logic [MUL_RES_W-1:0] acc, sq_out;
    logic [MUL_SQ_W-1:0]  sq_in;

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            ops_a[k] = bus.i_req_a[MUL_OP_W*k +: MUL_OP_W];
            ops_b[k] = bus.i_req_b[MUL_OP_W*k +: MUL_OP_W];
        end
    end

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_vld && bus.i_req_valid[idx[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        bus.o_req_ready = '0;
        if (state == IDLE && i_nrst && grant_vld) bus.o_req_ready[grant_id] = 1'b1;
    end

    assign accept = |bus.o_req_ready;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sq_in     = '0;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef IB_MUL_QS_SCHED_ZERO_SKIP_EN
                    if (ops_a[grant_id] == '0 || ops_b[grant_id] == '0) state_nxt = RESP;
                    else                                                state_nxt = SQ_SUM;
`else
                    state_nxt = SQ_SUM;
`endif
                end
            end
            SQ_SUM: begin
                sq_in     = {1'b0, a_q} + {1'b0, b_q};
                state_nxt = SQ_DIF;
            end
            SQ_DIF: begin
                // Absolute difference; a wrapped subtraction would square the wrong value.
                sq_in     = (a_q >= b_q) ? {1'b0, a_q - b_q} : {1'b0, b_q - a_q};
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.i_rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    ib_mul_qs_sq9 u_sq9 (
        .x (sq_in),
        .y (sq_out)
    );

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            acc    <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q  <= ops_a[grant_id];
                        b_q  <= ops_b[grant_id];
                        id_q <= grant_id;
                        acc  <= '0;
                    end
                end
                SQ_SUM: acc <= sq_out;
                // Floor terms cancel: a+b and |a-b| always share parity.
                SQ_DIF: acc <= acc - sq_out;
                RESP: begin
                    if (bus.i_rsp_ready)
                        rr_ptr <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_rsp_valid = (state == RESP);
    assign bus.o_rsp_c     = acc;
    assign bus.o_rsp_id    = id_q;
    assign bus.o_busy      = (state != IDLE);

endmodule
